// File: rtl/fpu_mul_arbiter_pkg.sv
// Shared types for the fpuMul arbiter: operand format, multiplier status and the arbiter states.
package fpu_mul_arbiter_pkg;

  typedef logic [15:0] fp16_t;

  typedef struct packed {
    logic Z;
    logic C;
    logic N;
    logic V;
  } condCode_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_CLEAR,
    ARB_START,
    ARB_BUSY,
    ARB_RESP
  } fpuArbState_t;

endpackage

// File: rtl/fpu_mul_arbiter_if.sv
// Requester, response and multiplier-side signals of the arbiter.
// The slave view belongs to the arbiter; the master view to the clients plus multiplier.
interface fpu_mul_arbiter_if
  import fpu_mul_arbiter_pkg::*;
#(
  parameter int  NREQ = 4,
  parameter type FP_T = fp16_t
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] reqValid;
  logic [NREQ-1:0] reqReady;
  FP_T  [NREQ-1:0] reqIn1;
  FP_T  [NREQ-1:0] reqIn2;

  logic            rspValid;
  logic            rspReady;
  logic [IDW-1:0]  rspId;
  FP_T             rspOut;
  condCode_t       rspCondCodes;
  opStatusFlag_t   rspFlags;
  logic            rspErr;

  FP_T             mulIn1;
  FP_T             mulIn2;
  logic            mulStart;
  logic            mulReset;
  FP_T             mulOut;
  condCode_t       mulCondCodes;
  opStatusFlag_t   mulFlags;
  logic            mulDone;

  modport slave (
    input  reqValid, reqIn1, reqIn2, rspReady,
    input  mulOut, mulCondCodes, mulFlags, mulDone,
    output reqReady, rspValid, rspId, rspOut, rspCondCodes, rspFlags, rspErr,
    output mulIn1, mulIn2, mulStart, mulReset
  );

  modport master (
    output reqValid, reqIn1, reqIn2, rspReady,
    output mulOut, mulCondCodes, mulFlags, mulDone,
    input  reqReady, rspValid, rspId, rspOut, rspCondCodes, rspFlags, rspErr,
    input  mulIn1, mulIn2, mulStart, mulReset
  );

endinterface

// File: rtl/fpu_mul_arbiter_rr_picker.sv
// Round-robin picker (fpuRRPicker): one-hot grant to the first valid requester after lastGrant.
module fpu_mul_arbiter_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [IDW-1:0]  i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id,
  output logic            o_any_req
);

  // One extra bit holds lastGrant+k before the modulo fold, so non-power-of-two NREQ works.
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, i_last_grant} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
      w_idx = w_sum[IDW-1:0];
      if (!w_found && i_req_valid[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

  assign o_any_req = w_found;

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fpuMul among NREQ requesters: grant, reset+start the multiplier, return its result.
// States: IDLE wait/grant | CLEAR mulReset pulse | START mulStart pulse | BUSY wait mulDone/timeout | RESP hold result
module fpu_mul_arbiter
  import fpu_mul_arbiter_pkg::*;
#(
  parameter type FP_T    = fp16_t,
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 64,
  parameter int  IDW     = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  fpu_mul_arbiter_if.slave        bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fpuArbState_t    r_state;
  fpuArbState_t    w_state_next;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_id;
  logic            w_any_req;
  logic            w_handshake;
  logic            w_timeout;

  logic [IDW-1:0]  r_last_grant;
  logic [IDW-1:0]  r_op_id;
  FP_T             r_op_a;
  FP_T             r_op_b;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;

  FP_T             r_rsp_out;
  condCode_t       r_rsp_cc;
  opStatusFlag_t   r_rsp_flags;
  logic            r_rsp_err;
  logic [IDW-1:0]  r_rsp_id;

  logic            r_mul_reset;
  logic            r_mul_start;

  fpu_mul_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_picker (
    .i_req_valid  (bus.reqValid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_id   (w_grant_id),
    .o_any_req    (w_any_req)
  );

  // The picker only grants valid requesters, so a grant in IDLE is always a handshake.
  assign w_handshake  = (r_state == ARB_IDLE) && !reset && w_any_req;
  assign bus.reqReady = w_handshake ? w_grant : '0;
  assign w_cnt_inc    = r_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ARB_IDLE:  if (w_handshake) w_state_next = ARB_CLEAR;
      ARB_CLEAR: w_state_next = ARB_START;
      ARB_START: w_state_next = ARB_BUSY;
      ARB_BUSY: begin
        if (bus.mulDone) begin
          w_state_next = ARB_RESP;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_timeout    = 1'b1;
          w_state_next = ARB_RESP;
        end
      end
      ARB_RESP:  if (bus.rspReady) w_state_next = ARB_IDLE;
      default:   w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_op_id      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_rsp_out    <= '0;
      r_rsp_cc     <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_id     <= '0;
      r_mul_reset  <= 1'b0;
      r_mul_start  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mul_reset <= (w_state_next == ARB_CLEAR);
      r_mul_start <= (w_state_next == ARB_START);

      if (w_handshake) begin
        r_last_grant <= w_grant_id;
        r_op_id      <= w_grant_id;
        r_op_a       <= bus.reqIn1[w_grant_id];
        r_op_b       <= bus.reqIn2[w_grant_id];
      end

      // Counter saturates at TIMEOUT; BUSY is always left by then.
      if (r_state == ARB_START) begin
        r_cnt <= '0;
      end else if (r_state == ARB_BUSY && r_cnt != CW'(TIMEOUT)) begin
        r_cnt <= w_cnt_inc;
      end

      if (r_state == ARB_BUSY && w_state_next == ARB_RESP) begin
        r_rsp_id  <= r_op_id;
        r_rsp_err <= w_timeout;
        if (w_timeout) begin
          r_rsp_out   <= '0;
          r_rsp_cc    <= '0;
          r_rsp_flags <= '0;
        end else begin
          r_rsp_out   <= bus.mulOut;
          r_rsp_cc    <= bus.mulCondCodes;
          r_rsp_flags <= bus.mulFlags;
        end
      end
    end
  end

  // The multiplier parks in DONE until reset, so it is also held in reset with the arbiter.
  assign bus.mulReset     = reset | r_mul_reset;
  assign bus.mulStart     = r_mul_start;
  assign bus.mulIn1       = r_op_a;
  assign bus.mulIn2       = r_op_b;

  assign bus.rspValid     = (r_state == ARB_RESP);
  assign bus.rspId        = r_rsp_id;
  assign bus.rspOut       = r_rsp_out;
  assign bus.rspCondCodes = r_rsp_cc;
  assign bus.rspFlags     = r_rsp_flags;
  assign bus.rspErr       = r_rsp_err;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter with a small behavioural fpuMul model on the multiplier side.
module tb_fpu_mul_arbiter;
  import fpu_mul_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_mul_arbiter_if #(.NREQ(4), .FP_T(fp16_t)) bus ();

  fpu_mul_arbiter #(
    .FP_T    (fp16_t),
    .NREQ    (4),
    .TIMEOUT (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier model: latches operands on start, raises done 4 cycles later, stays done until reset.
  logic       m_hang = 1'b0;
  logic [2:0] m_cnt  = '0;
  fp16_t      m_a    = '0;
  fp16_t      m_b    = '0;

  function automatic fp16_t ref_mul(fp16_t a, fp16_t b);
    if (a == 16'h3E00 && b == 16'h4000) return 16'h4200;
    if (a == 16'hC000 && b == 16'h3800) return 16'hBC00;
    if (a == 16'h4000 && b == 16'h4000) return 16'h4400;
    if (a == 16'h3C00 && b == 16'h3C00) return 16'h3C00;
    return 16'h7E00;
  endfunction

  always @(posedge clock) begin
    if (bus.mulReset) begin
      m_cnt            <= '0;
      bus.mulDone      <= 1'b0;
      bus.mulOut       <= '0;
      bus.mulCondCodes <= '0;
      bus.mulFlags     <= '0;
    end else if (bus.mulStart) begin
      m_cnt <= 3'd3;
      m_a   <= bus.mulIn1;
      m_b   <= bus.mulIn2;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 3'd1;
      if (m_cnt == 3'd1 && !m_hang) begin
        bus.mulDone        <= 1'b1;
        bus.mulOut         <= ref_mul(m_a, m_b);
        bus.mulCondCodes.N <= ref_mul(m_a, m_b) >> 15 != 0;
        bus.mulCondCodes.Z <= (ref_mul(m_a, m_b) & 16'h7FFF) == 0;
        bus.mulCondCodes.C <= 1'b0;
        bus.mulCondCodes.V <= 1'b0;
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one request, checks the grant, completes the handshake and drops valid in T+1.
  task automatic issue(input logic [1:0] id, input fp16_t a, input fp16_t b,
                       input logic [3:0] exp_ready);
    bus.reqValid[id] = 1'b1;
    bus.reqIn1[id]   = a;
    bus.reqIn2[id]   = b;
    #1;
    chk("grant", 32'(bus.reqReady), 32'(exp_ready));
    @(posedge clock);
    #1;
    bus.reqValid[id] = 1'b0;
  endtask

  // Cycles from the handshake edge until rspValid, capped at limit.
  task automatic wait_rsp(input int limit, output int n);
    n = 1;
    while (!bus.rspValid && n < limit) begin
      tick();
      n++;
    end
  endtask

  int         n;
  int         pulses;
  int         ng;
  logic [3:0] grants [5];
  logic [3:0] exp_g  [5];

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reqValid = 4'b0001;
    bus.reqIn1   = '0;
    bus.reqIn2   = '0;
    bus.rspReady = 1'b1;
    for (int i = 0; i < 5; i++) grants[i] = '0;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    // reset values
    tick(); tick();
    chk("rst_reqReady", 32'(bus.reqReady), 0);
    chk("rst_rspValid", 32'(bus.rspValid), 0);
    chk("rst_mulStart", 32'(bus.mulStart), 0);
    chk("rst_mulReset", 32'(bus.mulReset), 1);
    chk("rst_rspOut",   32'(bus.rspOut),   0);
    reset        = 1'b0;
    bus.reqValid = '0;
    tick();
    chk("post_rst_mulReset", 32'(bus.mulReset), 0);

    // single request: 1.5 x 2.0 from requester 2
    issue(2'd2, 16'h3E00, 16'h4000, 4'b0100);
    chk("clr_mulReset", 32'(bus.mulReset), 1);
    chk("clr_mulStart", 32'(bus.mulStart), 0);
    chk("clr_reqReady", 32'(bus.reqReady), 0);
    tick();
    chk("st_mulReset", 32'(bus.mulReset), 0);
    chk("st_mulStart", 32'(bus.mulStart), 1);
    chk("st_mulIn1",   32'(bus.mulIn1),   32'h3E00);
    n = 2;
    pulses = 0;
    while (!bus.rspValid && n < 20) begin
      tick();
      n++;
      pulses += int'(bus.mulReset) + int'(bus.mulStart);
    end
    chk("single_latency", 32'(n), 7);
    chk("single_extra_pulses", 32'(pulses), 0);
    chk("single_out", 32'(bus.rspOut), 32'h4200);
    chk("single_id",  32'(bus.rspId),  2);
    chk("single_err", 32'(bus.rspErr), 0);
    chk("single_N",   32'(bus.rspCondCodes.N), 0);
    chk("single_Z",   32'(bus.rspCondCodes.Z), 0);
    tick();
    chk("single_done", 32'(bus.rspValid), 0);

    // operand isolation: -2.0 x 0.5, operand changed after handshake
    issue(2'd0, 16'hC000, 16'h3800, 4'b0001);
    bus.reqIn1[0] = 16'h4400;
    wait_rsp(20, n);
    chk("iso_latency", 32'(n), 7);
    chk("iso_mulIn1",  32'(bus.mulIn1), 32'hC000);
    chk("iso_out",     32'(bus.rspOut), 32'hBC00);
    chk("iso_N",       32'(bus.rspCondCodes.N), 1);
    chk("iso_id",      32'(bus.rspId), 0);
    tick();

    // response backpressure with requesters 1 and 3 still asking
    bus.rspReady = 1'b0;
    issue(2'd1, 16'h4000, 16'h4000, 4'b0010);
    bus.reqValid = 4'b1010;
    wait_rsp(20, n);
    chk("bp_latency", 32'(n), 7);
    chk("bp_out", 32'(bus.rspOut), 32'h4400);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_rspValid", 32'(bus.rspValid), 1);
      chk("bp_rspOut",   32'(bus.rspOut),   32'h4400);
      chk("bp_rspId",    32'(bus.rspId),    1);
      chk("bp_reqReady", 32'(bus.reqReady), 0);
    end
    bus.rspReady = 1'b1;
    tick();
    chk("bp_next_grant", 32'(bus.reqReady), 32'b1000);
    bus.reqValid = '0;
    tick();
    chk("bp_no_handshake", 32'(bus.mulReset), 0);

    // timeout: multiplier never finishes
    m_hang = 1'b1;
    issue(2'd2, 16'h3E00, 16'h4000, 4'b0100);
    wait_rsp(100, n);
    chk("to_latency", 32'(n), 67);
    chk("to_err", 32'(bus.rspErr), 1);
    chk("to_out", 32'(bus.rspOut), 0);
    chk("to_id",  32'(bus.rspId),  2);
    tick();
    m_hang = 1'b0;
    issue(2'd3, 16'h4000, 16'h4000, 4'b1000);
    wait_rsp(20, n);
    chk("after_to_latency", 32'(n), 7);
    chk("after_to_err", 32'(bus.rspErr), 0);
    chk("after_to_out", 32'(bus.rspOut), 32'h4400);
    chk("after_to_id",  32'(bus.rspId),  3);
    tick();

    // reset in the middle of BUSY
    m_hang = 1'b1;
    issue(2'd0, 16'h3C00, 16'h3C00, 4'b0001);
    repeat (5) tick();
    bus.reqValid = 4'b0100;
    reset = 1'b1;
    #1;
    chk("mid_rst_reqReady", 32'(bus.reqReady), 0);
    chk("mid_rst_rspValid", 32'(bus.rspValid), 0);
    chk("mid_rst_mulStart", 32'(bus.mulStart), 0);
    chk("mid_rst_mulReset", 32'(bus.mulReset), 1);
    chk("mid_rst_mulIn1",   32'(bus.mulIn1),   0);
    chk("mid_rst_rspOut",   32'(bus.rspOut),   0);
    tick();
    reset        = 1'b0;
    bus.reqValid = '0;
    m_hang       = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      pulses += int'(bus.rspValid) + int'(bus.mulStart);
    end
    chk("mid_rst_no_rsp", 32'(pulses), 0);

    // valid withdrawn in the grant cycle is not a handshake
    bus.reqIn1 = {4{16'h3C00}};
    bus.reqIn2 = {4{16'h3C00}};
    bus.reqValid = 4'b0010;
    #1;
    chk("withdraw_grant", 32'(bus.reqReady), 32'b0010);
    bus.reqValid = '0;
    tick();
    chk("withdraw_no_op", 32'(bus.mulReset), 0);

    // round robin with all requesters valid; requester 0 first after reset
    bus.reqValid = 4'b1111;
    ng = 0;
    for (int c = 0; c < 200 && ng < 5; c++) begin
      #1;
      if (bus.reqReady != 0) begin
        grants[ng] = bus.reqReady;
        ng++;
      end
      tick();
    end
    bus.reqValid = '0;
    chk("rr_count", 32'(ng), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(grants[i]), 32'(exp_g[i]));
    repeat (20) tick();
    chk("rr_drained", 32'(bus.rspValid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_mul_arbiter.md
# fpu_mul_arbiter

Round-robin arbiter and sequencer that shares one `fpuMul` floating-point multiplier among `NREQ` independent requesters. It accepts one operand pair at a time through a valid/ready handshake and registers the operands. It then drives the multiplier's reset and start pins in the order that unit needs, and returns the product, condition codes and status flags to the winning requester. It sits between the issue logic of the FPU clients and the single multiplier instance.

## Interface
Parameters:
- `FP_T`, `fp16_t`: operand/result type, passed through to the multiplier.
- `NREQ`, 4: number of requesters; must be at least 2.
- `TIMEOUT`, 64: maximum number of cycles spent in ARB_BUSY before the operation is aborted.
- `IDW`, `$clog2(NREQ)`: width of the requester ID.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `reqValid`  in  [NREQ]  requester i presents an operand pair.
- `reqIn1`, `reqIn2`  in  FP_T [NREQ]  operands.
- `reqReady`  out  [NREQ]  one-hot grant; the handshake completes when `reqValid[i] & reqReady[i]`.
- `rspValid`  out  1  a result is available.
- `rspReady`  in  1  the consumer accepts the result.
- `rspId`  out  IDW  index of the requester that owns the result.
- `rspOut`  out  FP_T  product.
- `rspCondCodes`  out  condCode_t  {Z,C,N,V} from the multiplier.
- `rspFlags`  out  opStatusFlag_t  multiplier status flags.
- `rspErr`  out  1  operation timed out.
- `mulIn1`, `mulIn2`  out  FP_T  registered operands driven to the multiplier.
- `mulStart`  out  1  start pulse to the multiplier.
- `mulReset`  out  1  reset to the multiplier.
- `mulOut`, `mulCondCodes`, `mulFlags`, `mulDone`  in  —  multiplier outputs.

## Operation
- The multiplier's FSM stays in DONE until it is reset. The arbiter therefore resets it before every operation.
- States:
  - ARB_IDLE: if any `reqValid`, the round-robin winner gets `reqReady` → ARB_CLEAR.
  - ARB_CLEAR: `mulReset`=1 for exactly one cycle → ARB_START.
  - ARB_START: `mulStart`=1 for exactly one cycle → ARB_BUSY.
  - ARB_BUSY: on `mulDone`, capture the result registers → ARB_RESP. If the counter reaches `TIMEOUT` first, set `rspErr`=1 and `rspOut`=0 → ARB_RESP.
  - ARB_RESP: hold `rspValid`; when `rspReady` is seen → ARB_IDLE.
- Round robin: the search starts at `lastGrant+1` modulo NREQ. `lastGrant` updates only on a completed handshake. Its reset value is NREQ-1, so requester 0 has first priority.
- Operands are latched into `opA`/`opB` on the handshake, and `mulIn1`/`mulIn2` are driven from these registers. The requester may change or drop its inputs afterwards.
- `reqReady` is 0 outside ARB_IDLE and is never given to a requester whose `reqValid` is 0.
- `mulDone` is ignored in ARB_IDLE, ARB_CLEAR and ARB_START.
- Response registers (`rspOut`, `rspCondCodes`, `rspFlags`, `rspErr`, `rspId`) stay stable while `rspValid`=1 and `rspReady`=0.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide. It clears on entry to ARB_BUSY and does not wrap.
- Deasserting `reqValid` in the same cycle as the grant is not a handshake: `lastGrant` is unchanged and the state stays in ARB_IDLE.

## Timing
- Handshake in cycle T.
- `mulReset` is high in T+1.
- `mulStart` is high in T+2.
- When `mulDone` is first seen in cycle T+2+L, `rspValid` rises in T+3+L.
- If `rspReady` is already high, ARB_IDLE is entered in T+4+L and the next grant can occur in that cycle, giving one bubble between operations.
- `mulReset = reset | (state==ARB_CLEAR)`, registered except for the asynchronous `reset` term.
- Reset values: state ARB_IDLE; `reqReady`=0, `rspValid`=0, `mulStart`=0 and `mulReset`=1 while `reset` is high; all data registers 0; `lastGrant`=NREQ-1.
- Reset in the middle of an operation aborts it: no response is produced and the captured operands are discarded.

## Structure
- Add to `fpu_lib.sv`: the `fpuArbState_t` enum (ARB_IDLE, ARB_CLEAR, ARB_START, ARB_BUSY, ARB_RESP).
- Reuse the existing `condCode_t` and `opStatusFlag_t`.
- Sub-module `fpuRRPicker` (combinational):
  - inputs: `reqValid`, `lastGrant`;
  - outputs: one-hot `grant`, `grantId`, `anyReq`.
- The FSM, the datapath registers and the timeout counter are in `fpu_mul_arbiter`.
- The multiplier is instantiated by the parent module, not inside the arbiter.

## Test plan
- **Single request:** requester 2 sends 0x3E00 × 0x4000 (1.5 × 2.0) with `rspReady`=1.
  - Expect `rspOut`=0x4200, `rspId`=2, `rspErr`=0.
  - Expect `mulReset` and `mulStart` each high for exactly one cycle, in that order.
- **Round-robin fairness:** all four requesters hold `reqValid` continuously.
  - Expect grants in the order 0, 1, 2, 3, 0; the second grant to any requester never comes before the others have been served.
- **Response backpressure:** `rspReady`=0 for 10 cycles while requester 1 is valid.
  - Expect `rspOut` to stay stable, no new grant, and `reqReady`=0 throughout.
- **Timeout:** the multiplier model never asserts `mulDone`.
  - Expect `rspErr`=1 and `rspOut`=0 after 64 cycles in ARB_BUSY; afterwards the next request completes normally.
- **Reset mid-operation:** assert `reset` during ARB_BUSY.
  - Expect all outputs to return to their reset values immediately and no response for the aborted operation.
  - After reset, requester 0 wins first.
- **Operand isolation:** change `reqIn1` the cycle after the handshake.
  - Expect the product to use the latched operands: 0xC000 × 0x3800 (−2.0 × 0.5) gives 0xBC00 (−1.0), `rspCondCodes.N`=1.
